dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data-memory port (the `mem_ctrl` write/read interface) between the CPU core and an auxiliary requester (debug/loader/DMA). Accepts at most one transaction at a time, sequences it through a fixed IDLE→ISSUE→WAIT→DONE cycle, and returns an acknowledge plus read data to the winning requester. Sits in `cpu_top` between `core`/aux master and `mem_ctrl`. Uses round-robin on simultaneous requests.

## Interface
- `ADDR_WIDTH`, 32, width of memory byte address.
- `DATA_WIDTH`, 32, width of write/read data.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `m0_req`, `m1_req`  in  1  request from core (m0) / aux (m1).
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  ADDR_WIDTH  request address.
- `m0_wdata`, `m1_wdata`  in  DATA_WIDTH  write data.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  DATA_WIDTH  read result, valid with ack on reads.
- `mem_addr`  out  ADDR_WIDTH  address to memory.
- `mem_data`  out  DATA_WIDTH  write data to memory.
- `mem_we`  out  1  memory write enable.
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid one cycle after address presented.

## Operation
- Requester raises `req` with `we/addr/wdata` stable; holds them until its `ack`; must drop `req` (or present a new request) in the cycle after `ack`.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if no req, stay. Otherwise pick winner, latch its `we/addr/wdata` and port id, go ISSUE.
- Pick: only one req → that port. Both → port ≠ `last_grant`; then `last_grant` ← winner.
- ISSUE: `mem_addr/mem_data` = latched values; `mem_we` = latched `we` (exactly this one cycle). → WAIT.
- WAIT: `mem_addr` held; `mem_we` = 0; `mem_rdata` valid; on reads, capture into winner's `rdata` register. → DONE.
- DONE: winner's `ack` = 1; all `req` inputs ignored. → IDLE.
- Loser's request stays pending and is served from the next IDLE.
- Writes: ack issued, `rdata` of that port unchanged.
- Per-port `rdata` holds last read value until next read by that port.

## Timing
- Request sampled in IDLE at cycle t: `mem_we` high at t+1, rdata captured at t+2, `ack` high at t+3, IDLE again at t+4.
- Throughput: one transaction per 4 cycles; continuous alternating requesters each get one per 8 cycles.
- `ack` is registered, high exactly one cycle, never on both ports simultaneously.
- Reset (rst_n=0 at a rising edge): state IDLE, `last_grant`=1 (port 0 wins first tie), `mem_we`=0, `mem_addr`=0, `mem_data`=0, both `ack`=0, both `rdata`=0.
- Reset mid-transaction (any state): transaction dropped, no `ack`, no further `mem_we`; requester must reissue.
- Request arriving during ISSUE/WAIT/DONE: not sampled until IDLE.
- Addresses pass through unmodified (byte address; no alignment check).

## Structure
- Shared package `dmem_pkg`: state enum (IDLE, ISSUE, WAIT, DONE), port ids `PORT_CORE`=0, `PORT_AUX`=1, `MEM_LATENCY`=1.
- One sub-module: `rr_pick2` — combinational 2-request round-robin picker (inputs `req[1:0]`, `last`; outputs `grant`, `valid`).
- Rest (FSM, latches, output regs) in `dmem_arbiter`.

## Test plan
- Reset: hold `rst_n`=0 2 cycles with both reqs high → all outputs 0, no `mem_we` until released.
- m0 write addr 0x10 data 0xBEEF at t → `mem_we`=1 only at t+1 with `mem_addr`=0x10, `mem_data`=0xBEEF; `m0_ack` at t+3; `m0_rdata` unchanged.
- m1 read addr 0x20, memory model returns 0x1234 one cycle after address → `m1_rdata`=0x1234 with `m1_ack` at t+3; `mem_we` never 1.
- Both reqs held continuously from reset → grants 0,1,0,1 (acks at t+3, t+7, t+11, t+15), never both acks same cycle.
- m1 req rises at t+1 while m0 in ISSUE → m0 ack t+3, m1 latched at t+4, `m1_ack` at t+7.
- `rst_n`=0 during WAIT of m0 read → no `m0_ack`, `mem_we`=0; after release with both reqs, port 0 granted first.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    localparam logic PORT_CORE   = 1'b0;
    localparam logic PORT_AUX    = 1'b1;
    localparam int   MEM_LATENCY = 1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-request round-robin picker: a tie goes to the port that did not win last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between core (m0) and aux (m1) masters,
// one transaction at a time through IDLE/ISSUE/WAIT/DONE.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic                  port_q, port_d;
    logic                  we_q, we_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic [1:0]            ack_q, ack_d;
    logic                  pick_grant;
    logic                  pick_valid;

    rr_pick2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        port_d   = port_q;
        we_d     = we_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        mem_we_d = 1'b0;
        ack_d    = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ISSUE;
                    port_d  = pick_grant;
                    last_d  = pick_grant;
                    if (pick_grant == PORT_AUX) begin
                        we_d     = m1_we;
                        addr_d   = m1_addr;
                        data_d   = m1_wdata;
                        mem_we_d = m1_we;
                    end else begin
                        we_d     = m0_we;
                        addr_d   = m0_addr;
                        data_d   = m0_wdata;
                        mem_we_d = m0_we;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // Memory answers one cycle after the address; capture it here.
                if (!we_q) begin
                    if (port_q == PORT_AUX) rdata1_d = mem_rdata;
                    else                    rdata0_d = mem_rdata;
                end
                ack_d[port_q] = 1'b1;
                state_d       = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= PORT_AUX;
            port_q   <= PORT_CORE;
            we_q     <= 1'b0;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            port_q   <= port_d;
            we_q     <= we_d;
            mem_we_q <= mem_we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack_q    <= ack_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign mem_we   = mem_we_q;
    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic against a
// transaction-timing reference model and a shadow memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_data, mem_rdata;
    logic        mem_we;

    dmem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    // Memory device: registered read, one cycle latency.
    logic        pre_en = 1'b0;
    logic [7:0]  pre_a = 8'h00;
    logic [31:0] pre_d = 32'h0;
    logic [31:0] hw_mem [256];
    bit   [255:0] written;

    always @(posedge clk) begin
        if (pre_en) begin
            hw_mem[pre_a]  <= pre_d;
            written[pre_a] <= 1'b1;
        end else if (mem_we) begin
            hw_mem[mem_addr[7:0]]  <= mem_data;
            written[mem_addr[7:0]] <= 1'b1;
        end
        mem_rdata <= written[mem_addr[7:0]] ? hw_mem[mem_addr[7:0]]
                                            : seed(mem_addr[7:0]);
    end

    int errors = 0;
    int checks = 0;

    // Reference model: transaction timing as edge arithmetic.
    logic [31:0] ref_mem [256];
    int          n = 0;
    int          gcyc = -100;
    int          free_at = 0;
    logic        e_last = 1'b1;
    logic        t_port = 1'b0;
    logic        t_we = 1'b0;
    logic [31:0] t_addr = 32'h0, t_data = 32'h0;
    logic [31:0] e_addr = 32'h0, e_data = 32'h0;
    logic [31:0] e_rd0 = 32'h0, e_rd1 = 32'h0;
    logic        e_we, e_ack0, e_ack1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        if (!rst_n) begin
            free_at = n + 1;
            gcyc    = -100;
            e_last  = 1'b1;
            e_addr  = 32'h0;
            e_data  = 32'h0;
            e_rd0   = 32'h0;
            e_rd1   = 32'h0;
        end else begin
            if (n == gcyc + 2 && !t_we) begin
                if (t_port) e_rd1 = ref_mem[t_addr[7:0]];
                else        e_rd0 = ref_mem[t_addr[7:0]];
            end
            if (n >= free_at && (m0_req || m1_req)) begin
                t_port  = (m0_req && m1_req) ? ~e_last : m1_req;
                e_last  = t_port;
                t_we    = t_port ? m1_we : m0_we;
                t_addr  = t_port ? m1_addr : m0_addr;
                t_data  = t_port ? m1_wdata : m0_wdata;
                gcyc    = n;
                free_at = n + 4;
                e_addr  = t_addr;
                e_data  = t_data;
                if (t_we) ref_mem[t_addr[7:0]] = t_data;
            end
        end
        e_we   = (n == gcyc) && t_we;
        e_ack0 = (n == gcyc + 2) && !t_port;
        e_ack1 = (n == gcyc + 2) && t_port;
        @(posedge clk);
        #1;
        n++;
        chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_data", mem_data, e_data);
        chk("m0_ack", {31'b0, m0_ack}, {31'b0, e_ack0});
        chk("m1_ack", {31'b0, m1_ack}, {31'b0, e_ack1});
        chk("m0_rdata", m0_rdata, e_rd0);
        chk("m1_rdata", m1_rdata, e_rd1);
        chk("ack_excl", {31'b0, m0_ack & m1_ack}, 32'h0);
    endtask

    int          q[$];
    logic [31:0] r;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = seed(8'(i));
        rst_n    = 1'b0;
        m0_req   = 1'b1;
        m0_we    = 1'b1;
        m0_addr  = 32'h0000_0104;
        m0_wdata = 32'h1111_2222;
        m1_req   = 1'b1;
        m1_we    = 1'b0;
        m1_addr  = 32'h0000_0208;
        m1_wdata = 32'h0;
        tick();
        tick();
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);

        // Both requests held from reset: strict alternation from port 0.
        rst_n = 1'b1;
        repeat (16) begin
            tick();
            if (m0_ack) q.push_back(0);
            if (m1_ack) q.push_back(1);
        end
        chk("rr_count", q.size(), 32'd4);
        for (int i = 0; i < 4 && i < q.size(); i++)
            chk("rr_order", q[i], i % 2);
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();

        // m0 write
        m0_we    = 1'b1;
        m0_addr  = 32'h10;
        m0_wdata = 32'hBEEF;
        m0_req   = 1'b1;
        tick();
        chk("wr_we", {31'b0, mem_we}, 32'h1);
        chk("wr_addr", mem_addr, 32'h10);
        tick();
        tick();
        chk("wr_ack", {31'b0, m0_ack}, 32'h1);
        m0_req = 1'b0;
        tick();

        // m1 read of preloaded word
        pre_en       = 1'b1;
        pre_a        = 8'h20;
        pre_d        = 32'h1234;
        ref_mem[8'h20] = 32'h1234;
        tick();
        pre_en  = 1'b0;
        m1_we   = 1'b0;
        m1_addr = 32'h20;
        m1_req  = 1'b1;
        tick();
        tick();
        tick();
        chk("rd_ack", {31'b0, m1_ack}, 32'h1);
        chk("rd_data", m1_rdata, 32'h1234);
        m1_req = 1'b0;
        tick();

        // m1 arrives while m0 is in flight
        m0_we   = 1'b0;
        m0_addr = 32'h30;
        m0_req  = 1'b1;
        tick();
        m1_we    = 1'b1;
        m1_addr  = 32'h44;
        m1_wdata = 32'hCAFE;
        m1_req   = 1'b1;
        tick();
        tick();
        chk("ovl_m0_ack", {31'b0, m0_ack}, 32'h1);
        m0_req = 1'b0;
        repeat (4) tick();
        chk("ovl_m1_ack", {31'b0, m1_ack}, 32'h1);
        m1_req = 1'b0;
        tick();

        // Reset while m0 read is in WAIT
        m0_req = 1'b1;
        tick();
        tick();
        rst_n   = 1'b0;
        m1_we   = 1'b0;
        m1_addr = 32'h50;
        m1_req  = 1'b1;
        tick();
        chk("rst_no_ack", {31'b0, m0_ack}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_regrant", mem_addr, 32'h30);
        tick();
        tick();
        chk("rst_m0_ack", {31'b0, m0_ack}, 32'h1);
        m0_req = 1'b0;
        repeat (4) tick();
        chk("rst_m1_ack", {31'b0, m1_ack}, 32'h1);
        m1_req = 1'b0;
        tick();

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
            if (e_ack0) m0_req = 1'b0;
            if (e_ack1) m1_req = 1'b0;
            if (!m0_req && $urandom_range(0, 2) == 0) begin
                r        = $urandom;
                m0_we    = r[31];
                m0_addr  = {r[30:8], 5'h0, r[3:0]};
                m0_wdata = $urandom;
                m0_req   = 1'b1;
            end
            if (!m1_req && $urandom_range(0, 2) == 0) begin
                r        = $urandom;
                m1_we    = r[31];
                m1_addr  = {r[30:8], 5'h0, r[3:0]};
                m1_wdata = $urandom;
                m1_req   = 1'b1;
            end
        end
        rst_n  = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
